// File: rtl/crc8_frame_encoder.sv
// crc8_frame_encoder
//   Passes a byte stream through unchanged and appends one CRC-8 byte
//   (MSB-first, non-reflected) after the last data byte of each frame.
//   A downstream CRC-8 checker with the same polynomial then sees a zero
//   residue when XOR_OUT is 0.
//
// Parameters
//   INIT     CRC register value at frame start
//   XOR_OUT  value XORed into the CRC before it is appended
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   gen[7:0]           generator polynomial, low 8 bits (x^8 implicit)
//   s_valid/s_ready    input handshake
//   s_data[7:0]        input byte
//   s_last             s_data is the last data byte of the frame
//   m_valid/m_ready    output handshake (single registered stage)
//   m_data[7:0]        output byte (data or CRC)
//   m_last             m_data is the appended CRC byte
//   done               high on the cycle the CRC byte transfers
module crc8_frame_encoder #(
  parameter logic [7:0] INIT    = 8'h00,
  parameter logic [7:0] XOR_OUT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] gen,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       done
);

  localparam logic [0:0] PASS   = 1'b0;
  localparam logic [0:0] APPEND = 1'b1;

  logic [0:0] state;
  logic [7:0] crc;
  logic [7:0] gen_q;
  logic       sof;

  logic       out_free;
  logic       in_xfer;
  logic [7:0] gen_use;
  logic [7:0] crc_next;

  // Full byte update in one cycle: 8 unrolled shift/conditional-xor steps.
  function automatic logic [7:0] crc_step(input logic [7:0] c_in,
                                          input logic [7:0] b,
                                          input logic [7:0] g);
    logic [7:0] c;
    c = c_in ^ b;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ g) : {c[6:0], 1'b0};
    return c;
  endfunction

  // Output register can take a new byte when empty or draining this cycle.
  assign out_free = !m_valid || m_ready;
  assign s_ready  = (state == PASS) && out_free;
  assign in_xfer  = s_valid && s_ready;

  // First byte of a frame uses the live polynomial; it is latched at the
  // same time so mid-frame changes of gen do not affect this frame.
  assign gen_use  = sof ? gen : gen_q;
  assign crc_next = crc_step(crc, s_data, gen_use);

  assign done = m_valid && m_ready && m_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PASS;
      crc     <= INIT;
      gen_q   <= 8'h00;
      sof     <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_last  <= 1'b0;
    end else if (in_xfer) begin
      m_data  <= s_data;
      m_valid <= 1'b1;
      m_last  <= 1'b0;
      crc     <= crc_next;
      sof     <= 1'b0;
      if (sof)
        gen_q <= gen;
      if (s_last)
        state <= APPEND;
    end else if (state == APPEND && out_free) begin
      m_data  <= crc ^ XOR_OUT;
      m_valid <= 1'b1;
      m_last  <= 1'b1;
      crc     <= INIT;
      sof     <= 1'b1;
      state   <= PASS;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc8_frame_encoder.sv
module tb_crc8_frame_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] gen = 8'h07;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       done;

  int checks = 0;
  int failures = 0;

  crc8_frame_encoder #(.INIT(8'h00), .XOR_OUT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .gen(gen),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .done(done)
  );

  always #5 clk = ~clk;

  // Downstream ready: always high, or a coin flip each cycle.
  bit rand_rdy = 0;
  always @(posedge clk) begin
    #1;
    m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor, sampled on the falling edge (between active edges).
  logic [8:0] outq[$];
  logic [8:0] expq[$];
  int done_cnt = 0, stall_cnt = 0, hold_viol = 0;
  bit hold = 0;
  logic [7:0] hd;
  logic hl;
  always @(negedge clk) begin
    if (!rst_n) hold = 0;
    else begin
      if (hold && (m_data !== hd || m_last !== hl)) hold_viol++;
      hold = m_valid && !m_ready;
      hd = m_data;
      hl = m_last;
      if (m_valid && m_ready) outq.push_back({m_last, m_data});
      if (done) done_cnt++;
      if (s_valid && !s_ready) stall_cnt++;
    end
  end

  // Reference: CRC as the remainder of (message * x^8) divided by the
  // generator, done as augmented bit-serial long division.
  function automatic logic [7:0] ref_crc(input logic [7:0] d[$], input logic [7:0] g);
    logic [7:0] r = 8'h00;
    logic top;
    int nbits = d.size() * 8 + 8;
    for (int k = 0; k < nbits; k++) begin
      logic bitv;
      bitv = (k < d.size() * 8) ? d[k / 8][7 - (k % 8)] : 1'b0;
      top = r[7];
      r = {r[6:0], bitv};
      if (top) r = r ^ g;
    end
    return r;
  endfunction

  task automatic expect_frame(input logic [7:0] d[$], input logic [7:0] g);
    foreach (d[i]) expq.push_back({1'b0, d[i]});
    expq.push_back({1'b1, ref_crc(d, g)});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit acc;
    int k = 0;
    s_valid = 1'b1;
    s_data = b;
    s_last = last;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 1000);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=no_accept want=accept byte=%02h", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] d[$], input bit drop);
    foreach (d[i]) send_byte(d[i], i == d.size() - 1);
    if (drop) s_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (outq.size() < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    outq.delete();
    expq.delete();
    done_cnt = 0;
    stall_cnt = 0;
    hold_viol = 0;
  endtask

  logic [7:0] s9[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data got=%02h want=00", m_data); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last got=%b want=0", m_last); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", done); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_single_byte();
    clear_obs();
    gen = 8'h07;
    send_frame('{8'h01}, 1);
    wait_out(2);
    checks++; if (outq.size() != 2) begin failures++; $display("FAIL single_count got=%0d want=2", outq.size()); end
    for (int i = 0; i < 2 && i < outq.size(); i++) begin
      logic [8:0] w;
      w = (i == 0) ? 9'h001 : 9'h107;
      checks++; if (outq[i] !== w) begin failures++; $display("FAIL single_out[%0d] got=%03h want=%03h", i, outq[i], w); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL single_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] w[4] = '{9'h0FF, 9'h1F3, 9'h080, 9'h189};
    clear_obs();
    gen = 8'h07;
    send_frame('{8'hFF}, 0);
    send_frame('{8'h80}, 1);
    wait_out(4);
    checks++; if (outq.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", outq.size()); end
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      checks++; if (outq[i] !== w[i]) begin failures++; $display("FAIL b2b_out[%0d] got=%03h want=%03h", i, outq[i], w[i]); end
    end
    checks++; if (stall_cnt != 1) begin failures++; $display("FAIL b2b_stall got=%0d want=1", stall_cnt); end
    checks++; if (done_cnt != 2) begin failures++; $display("FAIL b2b_done got=%0d want=2", done_cnt); end
  endtask

  task automatic test_check_string(input bit rnd);
    logic [7:0] ob[$];
    clear_obs();
    gen = 8'h07;
    rand_rdy = rnd;
    send_frame(s9, 1);
    wait_out(10);
    rand_rdy = 0;
    checks++; if (outq.size() != 10) begin failures++; $display("FAIL str%0d_count got=%0d want=10", rnd, outq.size()); end
    for (int i = 0; i < 10 && i < outq.size(); i++) begin
      logic [8:0] w;
      w = (i < 9) ? {1'b0, s9[i]} : 9'h1F4;
      checks++; if (outq[i] !== w) begin failures++; $display("FAIL str%0d_out[%0d] got=%03h want=%03h", rnd, i, outq[i], w); end
      ob.push_back(outq[i][7:0]);
    end
    checks++; if (ref_crc(ob, 8'h07) !== 8'h00) begin failures++; $display("FAIL str%0d_residue got=%02h want=00", rnd, ref_crc(ob, 8'h07)); end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL str%0d_hold got=%0d want=0", rnd, hold_viol); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL str%0d_done got=%0d want=1", rnd, done_cnt); end
  endtask

  task automatic test_gen_change();
    logic [7:0] d1[$], d2[$];
    clear_obs();
    for (int i = 0; i < 5; i++) d1.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) d2.push_back(8'($urandom));
    gen = 8'h07;
    expect_frame(d1, 8'h07);
    expect_frame(d2, 8'h31);
    send_byte(d1[0], 1'b0);
    gen = 8'h31;
    for (int i = 1; i < 5; i++) send_byte(d1[i], i == 4);
    send_frame(d2, 1);
    wait_out(expq.size());
    checks++; if (outq.size() != expq.size()) begin failures++; $display("FAIL gen_count got=%0d want=%0d", outq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checks++; if (outq[i] !== expq[i]) begin failures++; $display("FAIL gen_out[%0d] got=%03h want=%03h", i, outq[i], expq[i]); end
    end
  endtask

  task automatic test_random();
    clear_obs();
    rand_rdy = 1;
    for (int f = 0; f < 12; f++) begin
      logic [7:0] d[$];
      logic [7:0] g;
      int n;
      n = $urandom_range(1, 8);
      g = 8'($urandom);
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      gen = g;
      expect_frame(d, g);
      send_frame(d, $urandom_range(0, 1));
    end
    s_valid = 1'b0;
    wait_out(expq.size());
    rand_rdy = 0;
    checks++; if (outq.size() != expq.size()) begin failures++; $display("FAIL rnd_count got=%0d want=%0d", outq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checks++; if (outq[i] !== expq[i]) begin failures++; $display("FAIL rnd_out[%0d] got=%03h want=%03h", i, outq[i], expq[i]); end
    end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL rnd_hold got=%0d want=0", hold_viol); end
    checks++; if (done_cnt != 12) begin failures++; $display("FAIL rnd_done got=%0d want=12", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int nb, dc;
    clear_obs();
    gen = 8'h07;
    for (int i = 0; i < 4; i++) send_byte(s9[i], 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0) begin
      failures++; $display("FAIL midrst_clear got=%b/%02h/%b want=0/00/0", m_valid, m_data, m_last);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nb = outq.size();
    dc = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (outq.size() != nb || done_cnt != dc) begin
      failures++; $display("FAIL midrst_no_crc got=%0d_extra want=0_extra", outq.size() - nb + done_cnt - dc);
    end
    clear_obs();
    send_frame('{8'h01}, 1);
    wait_out(2);
    checks++; if (outq.size() != 2) begin failures++; $display("FAIL midrst_count got=%0d want=2", outq.size()); end
    if (outq.size() == 2) begin
      checks++; if (outq[0] !== 9'h001 || outq[1] !== 9'h107) begin
        failures++; $display("FAIL midrst_frame got=%03h,%03h want=001,107", outq[0], outq[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_check_string(0);
    test_check_string(1);
    test_gen_change();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
